// File: rtl/adder_issue_ctrl.sv
// adder_issue_ctrl: sequencing and result-capture stage around the external
// combinational add/sub adder. Accepts one request at a time, drives the
// adder from registered operands, derives N/Z/C/V from the returned sum,
// updates a running accumulator and queues results in a 2-entry FIFO.
// Optional feature macro: ADDER_ISSUE_SAT_EN (saturate on signed overflow).
module adder_issue_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_flag,
  input  logic [WIDTH:0]   add_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_c,
  output logic             out_v,
  output logic             out_n,
  output logic             out_z,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             n;
    logic             z;
  } entry_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             flag_q, flag_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  entry_t           fifo_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;

  logic             push;
  logic             pop;
  logic             full;

  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] final_res;
  entry_t           new_entry;
  entry_t           head;

  assign out_valid = (cnt_q != 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign pop       = out_valid && out_ready;

  // Result capture: overflow and flags are judged against the operands
  // currently held on the adder inputs.
  always_comb begin
    sum = add_z[WIDTH-1:0];
    if (flag_q) begin
      ovf = (x_q[MSB] == y_q[MSB]) && (sum[MSB] != x_q[MSB]);
    end else begin
      ovf = (x_q[MSB] != y_q[MSB]) && (sum[MSB] != x_q[MSB]);
    end
    final_res = sum;
`ifdef ADDER_ISSUE_SAT_EN
    // Overflow direction follows the sign of x: positive x can only overflow
    // upward, negative x only downward.
    if (ovf) begin
      final_res = x_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    new_entry.res = final_res;
    new_entry.c   = add_z[WIDTH];
    new_entry.v   = ovf;
    new_entry.n   = final_res[MSB];
    new_entry.z   = (final_res == '0);
  end

  // Next-state and handshake decode; in_ready depends on state only.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    flag_d   = flag_q;
    in_ready = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_acc ? acc_q : in_a;
          y_d     = in_b;
          flag_d  = !in_sub;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A same-cycle pop frees a slot even when the FIFO is full.
        if (!full || pop) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator follows every pushed result.
  always_comb begin
    acc_d = push ? final_res : acc_q;
  end

  // FIFO occupancy update.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM, operand and accumulator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      flag_q  <= 1'b1;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      flag_q  <= flag_d;
      acc_q   <= acc_d;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= new_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  // Head presentation; fields read zero whenever the FIFO is empty.
  always_comb begin
    head    = fifo_q[rd_ptr_q];
    out_res = out_valid ? head.res : '0;
    out_c   = out_valid && head.c;
    out_v   = out_valid && head.v;
    out_n   = out_valid && head.n;
    out_z   = out_valid && head.z;
  end

  assign add_x    = x_q;
  assign add_y    = y_q;
  assign add_flag = flag_q;
  assign acc      = acc_q;

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Self-checking bench for adder_issue_ctrl with a behavioural adder and a
// queue-based reference model. Honours ADDER_ISSUE_SAT_EN if defined.
module tb_adder_issue_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_sub;
  logic       in_acc;
  logic [7:0] add_x;
  logic [7:0] add_y;
  logic       add_flag;
  logic [8:0] add_z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       out_c;
  logic       out_v;
  logic       out_n;
  logic       out_z;
  logic [7:0] acc;

  int n_vec  = 0;
  int n_miss = 0;

  adder_issue_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
    .add_x(add_x), .add_y(add_y), .add_flag(add_flag), .add_z(add_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_c(out_c), .out_v(out_v), .out_n(out_n), .out_z(out_z),
    .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: flag=1 add, flag=0 subtract as x + ~y + 1.
  always_comb begin
    if (add_flag) add_z = {1'b0, add_x} + {1'b0, add_y};
    else          add_z = {1'b0, add_x} + {1'b0, ~add_y} + 9'd1;
  end

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       n;
    logic       z;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference result from signed/unsigned integer arithmetic.
  function automatic res_t model_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
    res_t r;
    int sa, sb, exact, ua, ub;
    logic [31:0] t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    exact = sub ? (sa - sb) : (sa + sb);
    r.c = sub ? (ua >= ub) : ((ua + ub) > 255);
    r.v = (exact > 127) || (exact < -128);
    t = exact;
    r.res = t[7:0];
`ifdef ADDER_ISSUE_SAT_EN
    if (r.v) r.res = (exact > 127) ? 8'h7F : 8'h80;
`endif
    r.n = r.res[7];
    r.z = (r.res == 8'h00);
    return r;
  endfunction

  // Reference model state: at most one op in flight, plus an ordered queue.
  res_t       q[$];
  logic       busy;
  res_t       pend;
  logic [7:0] pend_x, pend_y;
  logic       pend_flag;
  logic [7:0] acc_m;

  initial begin
    busy = 1'b0;
    acc_m = 8'h00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      busy = 1'b0;
      q.delete();
      acc_m = 8'h00;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_acc", {24'b0, acc}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    end else begin
      logic pop_m, push_m;
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, !busy});
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk("m_acc", {24'b0, acc}, {24'b0, acc_m});
      if (q.size() > 0) begin
        chk("m_out_res", {24'b0, out_res}, {24'b0, q[0].res});
        chk("m_flags", {28'b0, out_c, out_v, out_n, out_z},
            {28'b0, q[0].c, q[0].v, q[0].n, q[0].z});
      end
      if (busy) begin
        chk("m_operands", {15'b0, add_flag, add_x, add_y}, {15'b0, pend_flag, pend_x, pend_y});
      end
      pop_m  = (q.size() > 0) && out_ready;
      push_m = busy && ((q.size() < 2) || pop_m);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(pend);
        acc_m = pend.res;
        busy = 1'b0;
      end else if (!busy && in_valid) begin
        pend_x    = in_acc ? acc_m : in_a;
        pend_y    = in_b;
        pend_flag = !in_sub;
        pend      = model_op(pend_x, pend_y, in_sub);
        busy      = 1'b1;
      end
    end
  end

  // Present a request and return once it has been accepted.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic ua);
    bit ok;
    ok = 0;
    in_a = a; in_b = b; in_sub = sub; in_acc = ua; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issue with an empty FIFO and out_ready=1; check latency and literal result.
  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic ua, input logic [7:0] er,
                       input logic ec, input logic ev, input logic en, input logic ez);
    int k;
    out_ready = 1'b1;
    issue(a, b, sub, ua);
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, k, 32'd2);
    chk({nm, "_res"}, {24'b0, out_res}, {24'b0, er});
    chk({nm, "_cvnz"}, {28'b0, out_c, out_v, out_n, out_z}, {28'b0, ec, ev, en, ez});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [7:0] got[$];
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_acc = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_add_flag", {31'b0, add_flag}, 32'd1);
    chk("reset_add_xy", {16'b0, add_x, add_y}, 32'd0);
    chk("reset_out_res", {24'b0, out_res}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    do_op("add", 8'h08, 8'hFB, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while an op is in ISSUE: nothing must be pushed.
    out_ready = 1'b1;
    issue(8'h11, 8'h22, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_acc", {24'b0, acc}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_push", {31'b0, out_valid}, 32'd0);
    end

`ifdef ADDER_ISSUE_SAT_EN
    do_op("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("ovf_sub", 8'h80, 8'h01, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
`else
    do_op("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    do_op("ovf_sub", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Back-pressure: two results stored, third op held in ISSUE.
    out_ready = 1'b0;
    issue(8'd1, 8'd2, 1'b0, 1'b0);
    issue(8'd3, 8'd4, 1'b0, 1'b0);
    issue(8'd5, 8'd6, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_head", {23'b0, out_valid, out_res}, {23'b0, 1'b1, 8'd3});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_res);
    end
    chk("bp_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("bp_order0", {24'b0, got[0]}, 32'd3);
      chk("bp_order1", {24'b0, got[1]}, 32'd7);
      chk("bp_order2", {24'b0, got[2]}, 32'd11);
    end

    // Accumulate chain from a clean accumulator.
    reset_pulse();
    do_op("acc1", 8'hAA, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("acc2", 8'hAA, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("acc3", 8'hAA, 8'h10, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("acc_value", {24'b0, acc}, 32'h30);
    do_op("acc_sub", 8'hAA, 8'h30, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized traffic checked by the reference model.
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_sub    = 1'($urandom);
      in_acc    = ($urandom_range(0, 3) == 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adder_issue_ctrl.md
# adder_issue_ctrl

Sequencing and result-capture stage wrapped around the combinational 8-bit add/sub `adder` of the ALU. It accepts operand requests over a valid/ready handshake, registers and drives them onto the adder's `x`/`y`/`flag` inputs, and captures the 9-bit `z`. From the captured result it derives N/Z/C/V flags, updates a running accumulator, and hands results downstream through a 2-entry output FIFO.

## Interface
- `WIDTH`, 8: operand width; the adder result is `WIDTH+1` bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_a` in WIDTH: operand A (ignored when `in_acc`=1).
- `in_b` in WIDTH: operand B.
- `in_sub` in 1: 1 = A−B, 0 = A+B.
- `in_acc` in 1: 1 = use accumulator as operand A.
- `add_x` out WIDTH: registered operand to adder `x`.
- `add_y` out WIDTH: registered operand to adder `y`.
- `add_flag` out 1: to adder `flag`; 1 = add, 0 = subtract.
- `add_z` in WIDTH+1: adder result; [WIDTH-1:0] = sum, [WIDTH] = carry-out.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: pop FIFO head when `out_valid && out_ready`.
- `out_res` out WIDTH: result.
- `out_c`, `out_v`, `out_n`, `out_z` out 1 each: carry, signed overflow, negative, zero.
- `acc` out WIDTH: accumulator value.

## Operation
- FSM states: IDLE, ISSUE.
  - IDLE: `in_ready`=1. On accept, load `add_x` (= `acc` if `in_acc`, else `in_a`), `add_y`=`in_b`, `add_flag`=!`in_sub`; go to ISSUE.
  - ISSUE: `in_ready`=0. If the FIFO has space, or a pop occurs in the same cycle, push the result at the clock edge and return to IDLE. Otherwise hold in ISSUE with operands stable.
- Result and flag rules (x = `add_x`, y = `add_y`, r = `add_z`[7:0]):
  - `out_c` = `add_z`[8], passed through raw.
  - `out_v`: on add, x[7]==y[7] && r[7]!=x[7]. On subtract, x[7]!=y[7] && r[7]!=x[7].
  - `out_n` = final result bit 7.
  - `out_z` = (final result == 0).
- Accumulator: loaded with the final result on every push; unchanged otherwise.
- FIFO: 2 entries, in-order. Push and pop in the same cycle are allowed at any occupancy, including full.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Reset (`rst`=0, asynchronous):
  - state = IDLE, FIFO empty, `acc`=0.
  - `add_x`=`add_y`=0, `add_flag`=1.
  - `out_valid`=0, and `out_res` and all flags read 0.
  - An in-flight op is discarded.
- Latency:
  - Accept at edge N; ISSUE during cycle N+1; push at edge N+1.
  - `out_valid` is high from cycle N+2 when the FIFO was empty.
- Throughput: one op per 2 cycles without back-pressure.
- `in_ready` is registered-state-derived only; it never depends on `in_valid`.
- Dependent ops: an `in_acc` op accepted in IDLE always sees the result of the previous op, because only one op is in flight at a time.

## Configuration
- `ADDER_ISSUE_SAT_EN`:
  - Defined: when `out_v`=1, the result saturates to 0x7F (x[7]=0) or 0x80 (x[7]=1). `out_v` still reports 1, and `acc`, `out_n` and `out_z` use the saturated value.
  - Undefined: the wrapped adder result is used unchanged.

## Test plan
- Reset: assert `rst`=0 mid-ISSUE → immediately `out_valid`=0, `acc`=0, `in_ready`=1 after release, no push.
- Add: a=0x08, b=0xFB, sub=0 → `out_res`=0x03, C=1, V=0, N=0, Z=0, `out_valid` 2 cycles after accept.
- Overflow add: a=0x7F, b=0x01 → `out_res`=0x80, V=1, N=1, C=0. With `ADDER_ISSUE_SAT_EN`: `out_res`=0x7F, N=0.
- Overflow sub: a=0x80, b=0x01, sub=1 → `out_res`=0x7F, V=1. With the macro: `out_res`=0x80, N=1.
- Back-pressure: `out_ready`=0, issue 1+2, 3+4, 5+6 → FIFO holds 3 and 7, FSM holds in ISSUE, `in_ready`=0. Raise `out_ready` → 3, 7, 11 delivered in order, no loss or duplication.
- Accumulate: after reset, three ops with `in_acc`=1, b=0x10, add → results 0x10, 0x20, 0x30 and `acc`=0x30. A fourth op with sub, b=0x30 → 0x00, Z=1.
